// File: rtl/arb_pkg.sv
// Shared types and sizing for the 32-way round-robin priority arbiter.
package arb_pkg;

  localparam int NUM_REQ = 32;
  localparam int IDX_W   = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // last_id reset value: index 31 makes index 0 the first winner after reset
  localparam logic [IDX_W-1:0] LAST_ID_RST = 5'd31;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/lsb_priority_enc32.sv
// Lowest-index-first 32-to-5 priority encoder; purely combinational.
// No flow control: index is 0 and valid low when the vector is empty.
module lsb_priority_enc32
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] vec,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    idx   = '0;
    valid = |vec;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/priority_arbiter32.sv
// Round-robin 32-way arbiter with bounded hold; grant registered one cycle after req.
// No backpressure: holder keeps grant while requesting, preempted after MAX_HOLD cycles.
module priority_arbiter32
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
)
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_id,
  output logic               gnt_valid
);

  localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_t         state;
  logic [IDX_W-1:0]   last_id;
  logic [7:0]         hold_cnt;

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] above_mask;
  logic [IDX_W-1:0]   m_idx;
  logic [IDX_W-1:0]   f_idx;
  logic               m_valid;
  logic               f_valid;
  logic [IDX_W-1:0]   win_id;
  logic               win_valid;

  // The current holder is never a candidate: in IDLE gnt is zero, and in
  // BUSY a new winner is only needed when the holder drops or is preempted.
  assign cand       = req & ~gnt;
  assign above_mask = {{(NUM_REQ-1){1'b1}}, 1'b0} << last_id;

  lsb_priority_enc32 u_enc_masked (
    .vec   (cand & above_mask),
    .idx   (m_idx),
    .valid (m_valid)
  );

  lsb_priority_enc32 u_enc_full (
    .vec   (cand),
    .idx   (f_idx),
    .valid (f_valid)
  );

  assign win_id    = m_valid ? m_idx : f_idx;
  assign win_valid = f_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      hold_cnt  <= '0;
      last_id   <= LAST_ID_RST;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state     <= BUSY;
            gnt       <= idx_to_onehot(win_id);
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
            last_id   <= win_id;
            hold_cnt  <= '0;
          end else begin
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
          end
        end

        BUSY: begin
          if (req[gnt_id]) begin
            // >= rather than == so a saturated holder still yields once someone else arrives
            if (hold_cnt >= HOLD_LAST && win_valid) begin
              gnt      <= idx_to_onehot(win_id);
              gnt_id   <= win_id;
              last_id  <= win_id;
              hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end else if (win_valid) begin
            gnt      <= idx_to_onehot(win_id);
            gnt_id   <= win_id;
            last_id  <= win_id;
            hold_cnt <= '0;
          end else begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
          end
        end

        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_id    <= '0;
          gnt_valid <= 1'b0;
          hold_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_arbiter32.sv
// Directed-vector bench for priority_arbiter32 built with MAX_HOLD=4.
module tb_priority_arbiter32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] req;
  logic [31:0] gnt;
  logic [4:0]  gnt_id;
  logic        gnt_valid;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  priority_arbiter32 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_gnt(input string tag, input logic vld, input int id);
    logic [31:0] eg;
    logic [31:0] eid;
    eg  = vld ? (32'd1 << id) : 32'd0;
    eid = vld ? 32'(id) : 32'd0;
    check({tag, ".gnt"}, gnt, eg);
    check({tag, ".vld"}, {31'd0, gnt_valid}, {31'd0, vld});
    check({tag, ".id"},  {27'd0, gnt_id}, eid);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 32'd0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = 32'd0;
    step();
    expect_gnt("rst", 1'b0, 0);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      expect_gnt($sformatf("idle%0d", k), 1'b0, 0);
    end

    // first grant then handoff with no bubble
    do_reset();
    req = 32'h0000_0005;
    step();
    expect_gnt("first", 1'b1, 0);
    req = 32'h0000_0004;
    step();
    expect_gnt("handoff", 1'b1, 2);
    req = 32'd0;
    step();
    expect_gnt("release", 1'b0, 0);

    // wrap: last granted 31, then 31 and 0 both request
    do_reset();
    req = 32'h8000_0000;
    step();
    expect_gnt("g31", 1'b1, 31);
    req = 32'd0;
    step();
    expect_gnt("g31_drop", 1'b0, 0);
    req = 32'h8000_0001;
    step();
    expect_gnt("wrap", 1'b1, 0);

    // bounded hold: 3 held 4 cycles, then 7 for 4, then back to 3
    do_reset();
    req = 32'h0000_0088;
    for (int k = 0; k < 4; k++) begin
      step();
      expect_gnt($sformatf("hold3_%0d", k), 1'b1, 3);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      expect_gnt($sformatf("hold7_%0d", k), 1'b1, 7);
    end
    step();
    expect_gnt("back3", 1'b1, 3);

    // lone holder keeps grant past MAX_HOLD
    do_reset();
    req = 32'h0000_0008;
    for (int k = 0; k < 10; k++) begin
      step();
      expect_gnt($sformatf("lone%0d", k), 1'b1, 3);
    end

    // full rotation: every holder drops after one cycle
    do_reset();
    req = 32'hFFFF_FFFF;
    step();
    expect_gnt("rr_first", 1'b1, 0);
    for (int k = 1; k <= 32; k++) begin
      req = 32'hFFFF_FFFF & ~(32'd1 << (k - 1));
      step();
      expect_gnt($sformatf("rr%0d", k), 1'b1, k % 32);
    end

    // reset while busy drops grant on that edge and ignores req
    do_reset();
    req = 32'h0000_0200;
    step();
    expect_gnt("busy9", 1'b1, 9);
    step();
    expect_gnt("busy9_hold", 1'b1, 9);
    reset = 1'b1;
    step();
    expect_gnt("rst_busy", 1'b0, 0);
    step();
    expect_gnt("rst_hold", 1'b0, 0);
    reset = 1'b0;
    req   = 32'hFFFF_FFFF;
    step();
    expect_gnt("post_rst", 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
